// File: rtl/voice_allocator_pkg.sv
// voice_allocator_pkg: shared FSM encodings, event polarity constants and default widths
package voice_allocator_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECIDE = 2'd1;
  localparam logic [1:0] ST_FETCH  = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;
  localparam logic EV_ON  = 1'b1;
  localparam logic EV_OFF = 1'b0;
  localparam int NUM_VOICES_DEF = 8;
  localparam int NOTE_W_DEF     = 7;
  localparam int FREQ_W_DEF     = 24;
  localparam int AGE_W_DEF      = 3;
endpackage

// File: rtl/voice_allocator_if.sv
// voice_allocator_if: note-event valid/ready channel
//   ev_valid/ev_on/ev_note driven by the event source (master), ev_ready by the allocator (slave)
interface voice_allocator_if #(parameter int NOTE_W = 7);
  logic              ev_valid;
  logic              ev_ready;
  logic              ev_on;
  logic [NOTE_W-1:0] ev_note;
  modport master (output ev_valid, ev_on, ev_note, input ev_ready);
  modport slave  (input ev_valid, ev_on, ev_note, output ev_ready);
endinterface

// File: rtl/voice_allocator_voice_select.sv
// voice_select: combinational voice search for the allocator
//   key_on_i/voice_note_i/age_i: per-voice state; note_i: requested note
//   match_*: lowest active voice playing note_i; free_*: lowest idle voice; oldest_idx_o: oldest active voice
module voice_select #(
  parameter int NUM_VOICES = 8,
  parameter int NOTE_W     = 7,
  parameter int AGE_W      = 3,
  localparam int IDX_W     = $clog2(NUM_VOICES)
) (
  input  logic [NUM_VOICES-1:0]             key_on_i,
  input  logic [NUM_VOICES-1:0][NOTE_W-1:0] voice_note_i,
  input  logic [NUM_VOICES-1:0][AGE_W-1:0]  age_i,
  input  logic [NOTE_W-1:0]                 note_i,
  output logic                              match_hit_o,
  output logic [IDX_W-1:0]                  match_idx_o,
  output logic                              free_hit_o,
  output logic [IDX_W-1:0]                  free_idx_o,
  output logic [IDX_W-1:0]                  oldest_idx_o
);
  logic [AGE_W-1:0] best_age;
  always_comb begin
    match_hit_o  = 1'b0;
    match_idx_o  = '0;
    free_hit_o   = 1'b0;
    free_idx_o   = '0;
    oldest_idx_o = '0;
    best_age     = '0;
    // descending scan so the last hit is the lowest index
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (key_on_i[i] && voice_note_i[i] == note_i) begin
        match_hit_o = 1'b1;
        match_idx_o = IDX_W'(i);
      end
      if (!key_on_i[i]) begin
        free_hit_o = 1'b1;
        free_idx_o = IDX_W'(i);
      end
    end
    // ascending scan with strict compare keeps ties on the lowest index
    for (int i = 0; i < NUM_VOICES; i++)
      if (key_on_i[i] && age_i[i] > best_age) begin
        best_age     = age_i[i];
        oldest_idx_o = IDX_W'(i);
      end
  end
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic note-to-voice allocator driving a bank of NCOs
//   Clk, Reset_n (async active-low); ev: note-event channel (slave modport)
//   rom_addr/rom_data: registered note-to-frequency ROM (data one cycle after address)
//   voice_freq/voice_load/key_on: per-voice tuning word, update strobe, gate
//   all_busy: every voice gated; steal_drop: voice stolen (or note dropped)
//   Build option VOICE_STEAL_EN: steal the oldest voice when none is free, else drop the note
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int NOTE_W     = NOTE_W_DEF,
  parameter int FREQ_W     = FREQ_W_DEF,
  parameter int AGE_W      = AGE_W_DEF,
  localparam int IDX_W     = $clog2(NUM_VOICES)
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  voice_allocator_if.slave             ev,
  output logic [NOTE_W-1:0]            rom_addr,
  input  logic [FREQ_W-1:0]            rom_data,
  output logic [NUM_VOICES*FREQ_W-1:0] voice_freq,
  output logic [NUM_VOICES-1:0]        voice_load,
  output logic [NUM_VOICES-1:0]        key_on,
  output logic                         all_busy,
  output logic                         steal_drop
);
`ifdef VOICE_STEAL_EN
  localparam logic STEAL_EN = 1'b1;
`else
  localparam logic STEAL_EN = 1'b0;
`endif
  logic [1:0]                          state_q, state_d;
  logic                                on_q, on_d;
  logic [NOTE_W-1:0]                   note_q, note_d;
  logic [IDX_W-1:0]                    tgt_q, tgt_d;
  logic                                steal_q, steal_d;
  logic [NUM_VOICES-1:0]               key_on_q, key_on_d;
  logic [NUM_VOICES-1:0][FREQ_W-1:0]   freq_q, freq_d;
  logic [NUM_VOICES-1:0][NOTE_W-1:0]   vnote_q, vnote_d;
  logic [NUM_VOICES-1:0][AGE_W-1:0]    age_q, age_d;
  logic                                match_hit, free_hit, hit;
  logic [IDX_W-1:0]                    match_idx, free_idx, oldest_idx;
  voice_select #(.NUM_VOICES(NUM_VOICES), .NOTE_W(NOTE_W), .AGE_W(AGE_W)) u_sel (
    .key_on_i    (key_on_q),
    .voice_note_i(vnote_q),
    .age_i       (age_q),
    .note_i      (note_q),
    .match_hit_o (match_hit),
    .match_idx_o (match_idx),
    .free_hit_o  (free_hit),
    .free_idx_o  (free_idx),
    .oldest_idx_o(oldest_idx)
  );
  assign hit        = match_hit | free_hit;
  assign ev.ev_ready = state_q == ST_IDLE;
  assign rom_addr   = note_q;
  assign voice_freq = freq_q;
  assign key_on     = key_on_q;
  assign all_busy   = &key_on_q;
  assign voice_load = {NUM_VOICES{state_q == ST_COMMIT}} & (NUM_VOICES'(1) << tgt_q);
  assign steal_drop = STEAL_EN ? (state_q == ST_FETCH && steal_q)
                               : (state_q == ST_DECIDE && on_q == EV_ON && !hit);
  always_comb begin
    state_d  = state_q;
    on_d     = on_q;
    note_d   = note_q;
    tgt_d    = tgt_q;
    steal_d  = steal_q;
    key_on_d = key_on_q;
    freq_d   = freq_q;
    vnote_d  = vnote_q;
    age_d    = age_q;
    case (state_q)
      ST_IDLE: if (ev.ev_valid) begin
        on_d    = ev.ev_on;
        note_d  = ev.ev_note;
        state_d = ST_DECIDE;
      end
      ST_DECIDE: begin
        tgt_d   = match_hit ? match_idx : free_hit ? free_idx : oldest_idx;
        steal_d = STEAL_EN && !hit;
        state_d = ST_IDLE;
        if (on_q == EV_OFF) begin
          for (int i = 0; i < NUM_VOICES; i++)
            if (key_on_q[i] && vnote_q[i] == note_q) key_on_d[i] = 1'b0;
        end else if (hit || STEAL_EN) begin
          // a free voice is already gated off; retrigger/steal gets a one-cycle gap
          key_on_d[tgt_d] = 1'b0;
          state_d         = ST_FETCH;
        end
      end
      ST_FETCH: begin
        freq_d[tgt_q]   = rom_data;
        vnote_d[tgt_q]  = note_q;
        key_on_d[tgt_q] = 1'b1;
        state_d         = ST_COMMIT;
      end
      default: begin
        for (int i = 0; i < NUM_VOICES; i++)
          if (IDX_W'(i) == tgt_q) age_d[i] = '0;
          else if (key_on_q[i] && age_q[i] != AGE_W'(NUM_VOICES - 1)) age_d[i] = age_q[i] + 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      on_q     <= 1'b0;
      note_q   <= '0;
      tgt_q    <= '0;
      steal_q  <= 1'b0;
      key_on_q <= '0;
      freq_q   <= '0;
      vnote_q  <= '0;
      age_q    <= '0;
    end else begin
      state_q  <= state_d;
      on_q     <= on_d;
      note_q   <= note_d;
      tgt_q    <= tgt_d;
      steal_q  <= steal_d;
      key_on_q <= key_on_d;
      freq_q   <= freq_d;
      vnote_q  <= vnote_d;
      age_q    <= age_d;
    end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed self-checking bench for voice_allocator
module tb_voice_allocator;
  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic [6:0]   rom_addr;
  logic [23:0]  rom_data = '0;
  logic [191:0] voice_freq;
  logic [7:0]   voice_load, key_on;
  logic         all_busy, steal_drop;
  int           checks = 0, failures = 0;
  int           load_cnt = 0, steal_cnt = 0;
  int           low_cnt [8];
  logic [7:0]   last_load = '0;
  int           lat, l0, s0, g0;
  voice_allocator_if #(.NOTE_W(7)) bus ();
  voice_allocator dut (
    .Clk(Clk), .Reset_n(Reset_n), .ev(bus.slave), .rom_addr(rom_addr), .rom_data(rom_data),
    .voice_freq(voice_freq), .voice_load(voice_load), .key_on(key_on),
    .all_busy(all_busy), .steal_drop(steal_drop)
  );
  always #5 Clk = ~Clk;
  function automatic logic [23:0] rom_f(input logic [6:0] n);
    return n == 7'd69 ? 24'h0258BF : {8'hA5, 9'd0, n};
  endfunction
  always @(posedge Clk) rom_data <= rom_f(rom_addr);
  initial for (int i = 0; i < 8; i++) low_cnt[i] = 0;
  always @(negedge Clk) begin
    if (voice_load != 0) begin
      load_cnt++;
      last_load = voice_load;
    end
    if (steal_drop) steal_cnt++;
    for (int i = 0; i < 8; i++) if (!key_on[i]) low_cnt[i]++;
  end
  function automatic logic [23:0] vf(input int v);
    return voice_freq[v*24 +: 24];
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset_n = 1'b1;
  endtask
  task automatic ev(input logic on, input logic [6:0] note, output int n);
    n = 0;
    @(negedge Clk);
    while (!bus.ev_ready && n < 20) begin
      n++;
      @(negedge Clk);
    end
    bus.ev_valid = 1'b1;
    bus.ev_on    = on;
    bus.ev_note  = note;
    @(posedge Clk);
    #1 bus.ev_valid = 1'b0;
    n = 1;
    @(negedge Clk);
    while (!bus.ev_ready && n < 20) begin
      n++;
      @(negedge Clk);
    end
  endtask
  initial begin
    bus.ev_valid = 1'b0;
    bus.ev_on    = 1'b0;
    bus.ev_note  = '0;
    do_reset();
    @(negedge Clk);
    check("rst_key_on", key_on, 0);
    check("rst_load", voice_load, 0);
    check("rst_steal", steal_drop, 0);
    check("rst_ready", bus.ev_ready, 1);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_freq", {63'd0, |voice_freq}, 0);
    l0 = load_cnt;
    ev(1'b1, 7'd69, lat);
    check("on69_lat", lat, 4);
    check("on69_freq0", vf(0), 24'h0258BF);
    check("on69_key", key_on, 8'h01);
    check("on69_loads", load_cnt - l0, 1);
    check("on69_load_v", last_load, 8'h01);
    do_reset();
    ev(1'b1, 7'd60, lat);
    ev(1'b1, 7'd62, lat);
    ev(1'b1, 7'd64, lat);
    check("three_key", key_on, 8'h07);
    ev(1'b0, 7'd62, lat);
    check("off62_lat", lat, 2);
    check("off62_key", key_on, 8'h05);
    ev(1'b1, 7'd65, lat);
    check("on65_key", key_on, 8'h07);
    check("on65_load_v", last_load, 8'h02);
    check("on65_freq1", vf(1), rom_f(7'd65));
    do_reset();
    for (int i = 0; i < 8; i++) ev(1'b1, 7'(60 + i), lat);
    check("fill_key", key_on, 8'hFF);
    check("fill_busy", all_busy, 1);
    l0 = load_cnt;
    s0 = steal_cnt;
    g0 = low_cnt[0];
    ev(1'b1, 7'd70, lat);
    check("full_steal_cnt", steal_cnt - s0, 1);
    check("full_key", key_on, 8'hFF);
`ifdef VOICE_STEAL_EN
    check("steal_lat", lat, 4);
    check("steal_gap", low_cnt[0] - g0, 1);
    check("steal_loads", load_cnt - l0, 1);
    check("steal_load_v", last_load, 8'h01);
    check("steal_freq0", vf(0), rom_f(7'd70));
    ev(1'b1, 7'd71, lat);
    check("steal2_load_v", last_load, 8'h02);
    check("steal2_freq1", vf(1), rom_f(7'd71));
`else
    check("drop_lat", lat, 2);
    check("drop_loads", load_cnt - l0, 0);
    check("drop_freq0", vf(0), rom_f(7'd60));
    check("drop_freq7", vf(7), rom_f(7'd67));
`endif
    do_reset();
    ev(1'b1, 7'd64, lat);
    l0 = load_cnt;
    g0 = low_cnt[0];
    ev(1'b1, 7'd64, lat);
    check("retrig_key", key_on, 8'h01);
    check("retrig_gap", low_cnt[0] - g0, 1);
    check("retrig_loads", load_cnt - l0, 1);
    check("retrig_load_v", last_load, 8'h01);
    ev(1'b0, 7'd50, lat);
    check("off50_lat", lat, 2);
    check("off50_key", key_on, 8'h01);
    @(negedge Clk);
    bus.ev_valid = 1'b1;
    bus.ev_on    = 1'b1;
    bus.ev_note  = 7'd66;
    @(posedge Clk);
    #1 bus.ev_valid = 1'b0;
    @(posedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    check("arst_key", key_on, 0);
    check("arst_load", voice_load, 0);
    check("arst_steal", steal_drop, 0);
    check("arst_rom_addr", rom_addr, 0);
    check("arst_freq", {63'd0, |voice_freq}, 0);
    @(negedge Clk) Reset_n = 1'b1;
    @(negedge Clk);
    check("arst_ready", bus.ev_ready, 1);
    ev(1'b1, 7'd72, lat);
    check("arst_on72_load_v", last_load, 8'h01);
    check("arst_on72_key", key_on, 8'h01);
    check("arst_on72_freq0", vf(0), rom_f(7'd72));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphony controller between the SoC note-event source and a bank of NUM_VOICES NCOs.
- Accepts note-on/note-off events over a valid/ready handshake and assigns each note to a voice: retrigger same note, else free voice, else steal the oldest.
- Sequences the shared note-to-frequency ROM lookup.
- Drives per-voice frequency words, load strobes and the key_on gate vector.

Parameters:
- NUM_VOICES, 8, number of NCO voices managed.
- NOTE_W, 7, note number width and ROM address width.
- FREQ_W, 24, frequency tuning word width (ROM data width).
- AGE_W, 3, per-voice age counter width; must equal clog2(NUM_VOICES).

Ports:
- Clk  in  1  system clock (CLOCK_50 domain)
- Reset_n  in  1  asynchronous active-low reset
- ev_valid  in  1  event present
- ev_ready  out  1  event accepted when ev_valid & ev_ready
- ev_on  in  1  1 = note-on, 0 = note-off
- ev_note  in  NOTE_W  note number
- rom_addr  out  NOTE_W  note ROM address
- rom_data  in  FREQ_W  note ROM data; registered ROM, valid one cycle after rom_addr
- voice_freq  out  NUM_VOICES*FREQ_W  per-voice tuning word; voice v occupies bits [v*FREQ_W +: FREQ_W]
- voice_load  out  NUM_VOICES  one-cycle pulse when that voice's freq is updated
- key_on  out  NUM_VOICES  per-voice gate
- all_busy  out  1  all key_on bits set
- steal_drop  out  1  one-cycle pulse: voice stolen, or note dropped when stealing is compiled out

Behaviour:
- Reset (async, Reset_n = 0):
  - state = IDLE; all key_on, voice_load, steal_drop = 0.
  - All voice_freq, ages, voice_note registers and rom_addr = 0.
  - Reset mid-sequence aborts the event; no partial commit.
- States: IDLE, DECIDE, FETCH, COMMIT.
- ev_ready = 1 only in IDLE. On handshake, ev_on/ev_note are captured and state goes to DECIDE.
- rom_addr is driven from the captured note register; it is stable from DECIDE through COMMIT.
- DECIDE, note-off:
  - Clear key_on of every voice with key_on = 1 and voice_note = ev_note; go to IDLE.
  - No match: silently ignored, go to IDLE.
  - Latency: 2 cycles per note-off event.
- DECIDE, note-on: select target voice v by priority:
  1. Active voice with the same note (retrigger).
  2. Lowest-index voice with key_on = 0.
  3. Active voice with maximum age, ties to lowest index (steal); pulse steal_drop in FETCH.
  - key_on[v] is cleared in FETCH for cases 1 and 3, giving a one-cycle gate gap that forces envelope retrigger.
- FETCH: rom_data is valid this cycle. At the FETCH->COMMIT edge: voice_freq[v] <= rom_data; voice_note[v] <= note; key_on[v] <= 1.
- COMMIT:
  - voice_load[v] = 1 for exactly this cycle.
  - Ages: age[v] <= 0; every other active voice increments, saturating at NUM_VOICES-1.
  - Go to IDLE.
  - Latency: 4 cycles per note-on event (accept to IDLE).
- Events arriving while busy stall via ev_ready = 0; ev_valid must hold until accepted.
- Inactive voices keep their last voice_freq value; ages are ignored when key_on = 0.
- all_busy is combinational AND of key_on.

Optional Feature:
- Macro VOICE_STEAL_EN.
- Defined: priority case 3 steals the oldest voice as described.
- Undefined: a note-on with no match and no free voice is dropped in DECIDE. steal_drop pulses in DECIDE, no ROM fetch occurs, state returns to IDLE (2 cycles), and voice state is unchanged.

Decomposition:
- synth_pkg: state enum (IDLE, DECIDE, FETCH, COMMIT); EV_ON = 1'b1 and EV_OFF = 1'b0 constants; default width localparams.
- One sub-module, voice_select: combinational, takes key_on, voice_note, ages and note; outputs match_hit/match_idx, free_hit/free_idx, oldest_idx.
- The FSM, registers and age update stay in voice_allocator.

Test Plan:
- Reset, then note-on 69 with ROM model returning 24'h0258BF -> after 4 cycles voice_freq[0] = 24'h0258BF, key_on = 8'h01, voice_load[0] pulses once, ev_ready high again in the 5th cycle.
- Note-on 60, 62, 64 -> key_on = 8'h07. Note-off 62 -> key_on = 8'h05. Note-on 65 -> voice 1 reused, key_on = 8'h07.
- Note-on with 8 distinct notes 60..67, then note-on 70 (VOICE_STEAL_EN) -> voice 0 (oldest, note 60) reassigned, steal_drop pulses, key_on[0] low for exactly one cycle.
- Same fill, then note-on 70 without VOICE_STEAL_EN -> steal_drop pulses, key_on = 8'hFF, voice_freq unchanged, no voice_load.
- Note-on 64 twice -> second uses the same voice with a one-cycle key_on gap. Note-off 50 (inactive) -> no change, ev_ready back after 2 cycles.
- Assert Reset_n low during FETCH -> all outputs 0 immediately; after release ev_ready = 1 and next note-on allocates voice 0.
